// File: rtl/hamming74_decoder.sv
// Two-stage pipelined Hamming(7,4) decoder with valid/ready flow control,
// optional single-error correction and a saturating detected-error counter.
module hamming74_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             select,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       a,
    output logic [2:0]       syndrome,
    output logic             err_det,
    output logic             err_cor,
    output logic [CNT_W-1:0] err_count,
    input  logic             cnt_clr
);

    logic             s1_valid_q;
    logic [6:0]       s1_b_q;
    logic             s1_sel_q;
    logic [2:0]       s1_syn_q;
    logic             s2_valid_q;
    logic [3:0]       a_q;
    logic [2:0]       syn_q;
    logic             err_det_q;
    logic             err_cor_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic       s2_adv;
    logic       s1_load;
    logic       s1_move;
    logic [2:0] syn_in;
    logic [6:0] cw_fix;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign s1_load  = in_valid && in_ready;
    assign s1_move  = s1_valid_q && s2_adv;

    // Syndrome bits {s4,s2,s1}; position p of the codeword lives in b[p-1].
    assign syn_in[0] = b[0] ^ b[2] ^ b[4] ^ b[6];
    assign syn_in[1] = b[1] ^ b[2] ^ b[5] ^ b[6];
    assign syn_in[2] = b[3] ^ b[4] ^ b[5] ^ b[6];

    always_comb begin
        // NOTE: default assignment first so no path through this block infers a latch.
        cw_fix = s1_b_q;
        if (s1_sel_q && (s1_syn_q != 3'd0)) begin
            cw_fix[s1_syn_q - 3'd1] = ~s1_b_q[s1_syn_q - 3'd1];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (s1_load && (syn_in != 3'd0) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: the data registers are reset too, because the outputs they drive
    // must read zero while in reset, not just the valid flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_b_q     <= '0;
            s1_sel_q   <= 1'b0;
            s1_syn_q   <= '0;
            s2_valid_q <= 1'b0;
            a_q        <= '0;
            syn_q      <= '0;
            err_det_q  <= 1'b0;
            err_cor_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (s1_load) begin
                s1_valid_q <= 1'b1;
                s1_b_q     <= b;
                s1_sel_q   <= select;
                s1_syn_q   <= syn_in;
            end else if (s1_move) begin
                s1_valid_q <= 1'b0;
            end
            // S2 keeps its payload after a handshake; only the valid flag drops.
            if (s1_move) begin
                s2_valid_q <= 1'b1;
                a_q        <= {cw_fix[6], cw_fix[5], cw_fix[4], cw_fix[2]};
                syn_q      <= s1_syn_q;
                err_det_q  <= (s1_syn_q != 3'd0);
                err_cor_q  <= (s1_syn_q != 3'd0) && s1_sel_q;
            end else if (out_ready) begin
                s2_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign a         = a_q;
    assign syndrome  = syn_q;
    assign err_det   = err_det_q;
    assign err_cor   = err_cor_q;
    assign err_count = cnt_q;

endmodule

// File: doc/hamming74_decoder.md
Name: hamming74_decoder

Overview:
- Pipelined Hamming(7,4) single-error-correcting decoder. It is the receive-side counterpart of the team's 7-bit Hamming encoder.
- Accepts one 7-bit codeword per cycle over a valid/ready handshake. Computes the syndrome, optionally corrects a single-bit error, and returns 4 data bits plus status.
- Keeps a saturating count of detected errors for link-quality monitoring.

Parameters:
- CNT_W, 16, width of err_count; saturates at 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- select  input  1  1 = correct single-bit errors; 0 = detect only (data extracted uncorrected). Sampled with each accepted word.
- in_valid  input  1  codeword b valid.
- in_ready  output  1  decoder can accept b this cycle.
- b  input  7  codeword; position p (1..7) = b[p-1]. Bits: b[0]=p1, b[1]=p2, b[2]=d1, b[3]=p4, b[4]=d2, b[5]=d3, b[6]=d4.
- out_valid  output  1  a, syndrome and flags valid.
- out_ready  input  1  downstream accepts output.
- a  output  4  decoded data {d4,d3,d2,d1}.
- syndrome  output  3  {s4,s2,s1}; nonzero = erroneous position.
- err_det  output  1  syndrome != 0.
- err_cor  output  1  err_det && select (a bit was flipped).
- err_count  output  CNT_W  saturating count of accepted words with nonzero syndrome.
- cnt_clr  input  1  synchronous clear of err_count.

Behaviour:
- Reset (rst_n low, asynchronous): both stage-valid flags = 0, out_valid = 0, a = 0, syndrome = 0, err_det = 0, err_cor = 0, err_count = 0. in_ready = 1 from the first cycle after reset release.
- Syndrome is computed on codeword positions 1..7:
  - s1 = c1^c3^c5^c7
  - s2 = c2^c3^c6^c7
  - s4 = c4^c5^c6^c7
- Pipeline has 2 stages, each with its own valid bit:
  - S1 registers b, select and syndrome on acceptance (in_valid && in_ready).
  - S2 registers a, syndrome, err_det and err_cor.
- Correction (in S1→S2): if select && syndrome != 0, invert codeword position syndrome before extracting {c7,c6,c5,c3}. Otherwise extract the bits unchanged.
- Syndrome values are always 1..7, so any nonzero value addresses a real bit. Double errors are miscorrected silently; this is a known limitation, not an error case.
- Latency: 2 cycles from acceptance to out_valid with no stall. Throughput is 1 word per cycle.
- Advance conditions:
  - s2_adv = !s2_valid || out_ready.
  - S1 moves to S2 when s1_valid && s2_adv.
  - in_ready = !s1_valid || s2_adv (combinational; no bubble under continuous flow).
- Output handshake:
  - out_valid = s2_valid.
  - While out_valid && !out_ready, a, syndrome, err_det and err_cor hold stable.
  - out_valid never drops without an accepting handshake.
- err_count:
  - Increments on an S1 load whose syndrome != 0.
  - Saturates at all-ones (no wrap).
  - cnt_clr has priority; clear and increment in the same cycle → 0.
- Stall: no word is lost or duplicated under any pattern of out_ready.
- Reset mid-operation: all in-flight words are discarded, and no output is presented until new input arrives.

Test Plan:
- Clean word: b=7'b1001011 (data 4'b1000), select=1, out_ready=1 → out_valid 2 cycles later, a=4'b1000, syndrome=0, err_det=0, err_cor=0, err_count=0.
- Single error: b=7'b1001111 (position 3 flipped), select=1 → a=4'b1000, syndrome=3'd3, err_det=1, err_cor=1, err_count=1.
- Detect-only: b=7'b1011011 (position 5 flipped), select=0 → a=4'b1010 (uncorrected), syndrome=3'd5, err_det=1, err_cor=0, err_count increments.
- Backpressure: stream of all 16 encoded data values with random out_ready and in_valid → every output matches in order, and the output holds stable while stalled. With out_ready=0, in_ready drops after 2 words are buffered.
- Counter: set CNT_W=2 and feed 5 erroneous words → err_count sticks at 3. Assert cnt_clr together with an erroneous word → err_count=0.
- Reset mid-stream: drop rst_n with both stages full → out_valid=0 and err_count=0 immediately. After release, the first new word appears 2 cycles after acceptance.
